// File: rtl/cras_pkg.sv
// Shared types and register map for the cryptographic return-address stack.
package cras_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SPILL = 2'd1,
      FILL  = 2'd2
   } state_e;

   localparam logic [2:0] CFG_CTRL = 3'd0;
   localparam logic [2:0] CFG_KEY0 = 3'd1;
   localparam logic [2:0] CFG_BASE = 3'd5;

endpackage

// File: rtl/cras_lifo.sv
// Circular on-chip return-address buffer: push onto top, pop from top,
// and silently overwrite the oldest entry when pushing into a full buffer.
module cras_lifo #(
   parameter int W     = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [W-1:0]             din,
   output logic [W-1:0]             top,
   output logic [W-1:0]             bottom,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;

   // NOTE: the storage array has no reset; count alone decides which entries are valid.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         count  <= '0;
      end else if (pop) begin
         wr_ptr <= wr_ptr - PW'(1);
         count  <= count - CW'(1);
      end else if (push) begin
         wr_ptr <= wr_ptr + PW'(1);
         if (!full) count <= count + CW'(1);
      end
   end

   // Once full, the slot about to be overwritten is the oldest entry.
   assign top    = mem[wr_ptr - PW'(1)];
   assign bottom = mem[wr_ptr];
   assign full   = (count == FULL_CNT);
   assign empty  = (count == '0);

endmodule

// File: rtl/cras_top.sv
// Return-address stack with masked spill/refill of overflow entries to external
// memory and a small MMIO configuration port.
module cras_top
   import cras_pkg::*;
#(
   parameter int W         = 32,
   parameter int NKW       = 4,
   parameter int DEPTH     = 8,
   parameter int MEM_DEPTH = 1024
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [W-1:0]  addr_in,
   input  logic          branch,
   input  logic          ret,
   output logic          rdy,
   output logic          stack_full,
   output logic          stack_empty,
   output logic          stack_mismatch,
   input  logic          mem_rdy,
   input  logic [W-1:0]  mem_dout,
   output logic [W-1:0]  mem_din,
   output logic [W-1:0]  mem_addr,
   output logic          mem_rd,
   output logic          mem_wr,
   input  logic [2:0]    config_addr,
   input  logic [31:0]   config_din,
   input  logic          config_wr,
   output logic          RAS_ena
);

   localparam int SCW = $clog2(MEM_DEPTH + 1);
   localparam int CW  = $clog2(DEPTH) + 1;
   localparam logic [SCW-1:0] SPILL_MAX = SCW'(MEM_DEPTH);
   localparam logic [CW-1:0]  CNT_ONE   = CW'(1);

   state_e         state;
   logic [W-1:0]   key [NKW];
   logic [W-1:0]   base;
   logic [SCW-1:0] spill_cnt;
   logic           rdy_q;

   logic           lf_push, lf_pop, lf_full, lf_empty;
   logic [W-1:0]   lf_din, lf_top, lf_bottom;
   logic [CW-1:0]  lf_count;

   logic           accept, do_pop, do_push;
   logic [W-1:0]   key_cur;

   function automatic logic [W-1:0] key_of(input logic [SCW-1:0] idx);
      key_of = '0;
      for (int i = 0; i < NKW; i++)
         if (int'(idx) % NKW == i) key_of = key[i];
   endfunction

   function automatic logic [W-1:0] slot_addr(input logic [SCW-1:0] idx);
      return base + (W'(idx) << 2);
   endfunction

   // Spill and refill both index the key by the slot number, so masking round-trips.
   assign key_cur = key_of(spill_cnt);

   assign accept  = RAS_ena && (state == IDLE);
   assign do_pop  = accept && ret;
   assign do_push = accept && branch && !ret && !(lf_full && spill_cnt == SPILL_MAX);

   assign lf_pop  = do_pop && !lf_empty;
   assign lf_push = do_push || (state == FILL && mem_rdy);
   assign lf_din  = (state == FILL) ? (mem_dout ^ key_cur) : addr_in;

   cras_lifo #(.W(W), .DEPTH(DEPTH)) u_lifo (
      .clk    (clk),
      .rst    (rst),
      .push   (lf_push),
      .pop    (lf_pop),
      .din    (lf_din),
      .top    (lf_top),
      .bottom (lf_bottom),
      .count  (lf_count),
      .full   (lf_full),
      .empty  (lf_empty)
   );

   // NOTE: every register here is state, so only non-blocking assignments are used.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state          <= IDLE;
         spill_cnt      <= '0;
         rdy_q          <= 1'b1;
         stack_mismatch <= 1'b0;
         mem_rd         <= 1'b0;
         mem_wr         <= 1'b0;
         mem_addr       <= '0;
         mem_din        <= '0;
         RAS_ena        <= 1'b1;
         base           <= '0;
         for (int i = 0; i < NKW; i++) key[i] <= '0;
      end else begin
         stack_mismatch <= 1'b0;

         if (config_wr) begin
            if (config_addr == CFG_CTRL) RAS_ena <= config_din[0];
            if (config_addr == CFG_BASE) base <= W'(config_din);
            for (int i = 0; i < NKW; i++)
               if (config_addr == CFG_KEY0 + 3'(i)) key[i] <= W'(config_din);
         end

         case (state)
            IDLE: begin
               if (do_pop) begin
                  if (lf_empty || addr_in != lf_top) stack_mismatch <= 1'b1;
                  // Draining the last on-chip entry pulls the newest spilled one back.
                  if (!lf_empty && lf_count == CNT_ONE && spill_cnt != '0) begin
                     state     <= FILL;
                     rdy_q     <= 1'b0;
                     spill_cnt <= spill_cnt - SCW'(1);
                     mem_rd    <= 1'b1;
                     mem_addr  <= slot_addr(spill_cnt - SCW'(1));
                  end
               end else if (do_push && lf_full) begin
                  state    <= SPILL;
                  rdy_q    <= 1'b0;
                  mem_wr   <= 1'b1;
                  mem_addr <= slot_addr(spill_cnt);
                  mem_din  <= lf_bottom ^ key_cur;
               end
            end
            SPILL: begin
               if (mem_rdy) begin
                  mem_wr    <= 1'b0;
                  spill_cnt <= spill_cnt + SCW'(1);
                  state     <= IDLE;
                  rdy_q     <= 1'b1;
               end
            end
            FILL: begin
               if (mem_rdy) begin
                  mem_rd <= 1'b0;
                  state  <= IDLE;
                  rdy_q  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign rdy         = rdy_q || !RAS_ena;
   assign stack_empty = lf_empty && (spill_cnt == '0);
   assign stack_full  = lf_full && (spill_cnt == SPILL_MAX);

endmodule

// File: tb/tb_cras_top.sv
// Self-checking bench for cras_top: directed table, spill/refill sequences and
// randomized push/pop traffic against a queue-based reference stack.
module tb_cras_top;

   localparam int W         = 32;
   localparam int NKW       = 4;
   localparam int DEPTH     = 8;
   localparam int MEM_DEPTH = 1024;

   logic          clk = 1'b0;
   logic          rst;
   logic [W-1:0]  addr_in;
   logic          branch, ret;
   logic          rdy, stack_full, stack_empty, stack_mismatch;
   logic          mem_rdy;
   logic [W-1:0]  mem_dout, mem_din, mem_addr;
   logic          mem_rd, mem_wr;
   logic [2:0]    config_addr;
   logic [31:0]   config_din;
   logic          config_wr;
   logic          RAS_ena;

   always #5 clk = ~clk;

   cras_top #(.W(W), .NKW(NKW), .DEPTH(DEPTH), .MEM_DEPTH(MEM_DEPTH)) dut (
      .clk            (clk),
      .rst            (rst),
      .addr_in        (addr_in),
      .branch         (branch),
      .ret            (ret),
      .rdy            (rdy),
      .stack_full     (stack_full),
      .stack_empty    (stack_empty),
      .stack_mismatch (stack_mismatch),
      .mem_rdy        (mem_rdy),
      .mem_dout       (mem_dout),
      .mem_din        (mem_din),
      .mem_addr       (mem_addr),
      .mem_rd         (mem_rd),
      .mem_wr         (mem_wr),
      .config_addr    (config_addr),
      .config_din     (config_din),
      .config_wr      (config_wr),
      .RAS_ena        (RAS_ena)
   );

   // External memory: word-addressed, write captured on a completing edge.
   logic [31:0] ext_mem [2048];
   assign mem_dout = ext_mem[mem_addr[12:2]];
   always @(posedge clk) if (mem_wr && mem_rdy) ext_mem[mem_addr[12:2]] <= mem_din;

   int checks   = 0;
   int failures = 0;

   // Reference model: on-chip entries and spilled entries as plain values.
   logic [31:0] m_chip [$];
   logic [31:0] m_spill[$];
   logic [31:0] m_key  [NKW];
   logic [31:0] m_base;
   bit          m_ena;

   typedef struct {
      bit          is_pop;
      logic [31:0] a;
      bit          exp_mm;
      bit          exp_empty;
   } vec_t;
   vec_t vecs[7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic bit model_empty();
      return (m_chip.size() == 0) && (m_spill.size() == 0);
   endfunction

   task automatic model_reset();
      m_chip.delete();
      m_spill.delete();
      for (int i = 0; i < NKW; i++) m_key[i] = '0;
      m_base = '0;
      m_ena  = 1'b1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic cfg_write(input logic [2:0] a, input logic [31:0] d);
      config_addr = a; config_din = d; config_wr = 1'b1;
      @(posedge clk); #1;
      config_wr = 1'b0;
      if (a == 3'd0) m_ena = d[0];
      else if (a >= 3'd1 && a <= 3'd4) m_key[a - 3'd1] = d;
      else if (a == 3'd5) m_base = d;
   endtask

   task automatic wait_rdy();
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (rdy) ok = 1;
         else begin @(posedge clk); #1; end
      end
      if (!ok) check("rdy_timeout", rdy, 1);
   endtask

   task automatic finish_xfer(input bit wr, input logic [31:0] a, input logic [31:0] d, input bit rand_lat);
      bit done = 0;
      for (int i = 0; i < 64 && !done; i++) begin
         check(wr ? "spill_wr" : "fill_rd", wr ? mem_wr : mem_rd, 1);
         check("xfer_addr", mem_addr, a);
         if (wr) check("spill_din", mem_din, d);
         check("xfer_rdy", rdy, 0);
         mem_rdy = rand_lat ? ($urandom_range(0, 2) == 0) : 1'b1;
         if (i == 63) mem_rdy = 1'b1;
         done = mem_rdy;
         @(posedge clk); #1;
      end
      mem_rdy = 1'b0;
      check("xfer_end_rdy", rdy, 1);
      check("xfer_end_req", mem_wr | mem_rd, 0);
   endtask

   task automatic do_push(input logic [31:0] a, input bit rand_lat);
      bit spill = 0;
      logic [31:0] ev, exp_a, exp_d;
      wait_rdy();
      if (m_ena) begin
         if (m_chip.size() < DEPTH) m_chip.push_back(a);
         else if (m_spill.size() < MEM_DEPTH) begin
            ev    = m_chip.pop_front();
            exp_a = m_base + 4 * m_spill.size();
            exp_d = ev ^ m_key[m_spill.size() % NKW];
            m_spill.push_back(ev);
            m_chip.push_back(a);
            spill = 1;
         end
      end
      addr_in = a; branch = 1'b1;
      @(posedge clk); #1;
      branch = 1'b0;
      check("push_mismatch", stack_mismatch, 0);
      if (spill) finish_xfer(1, exp_a, exp_d, rand_lat);
      else begin
         check("push_rdy", rdy, 1);
         check("push_no_wr", mem_wr, 0);
      end
      check("push_empty", stack_empty, model_empty());
   endtask

   task automatic do_pop(input logic [31:0] a, input bit rand_lat);
      bit fill = 0, exp_mm = 0;
      logic [31:0] top, exp_a;
      wait_rdy();
      if (m_ena) begin
         if (m_chip.size() == 0) exp_mm = 1;
         else begin
            top    = m_chip.pop_back();
            exp_mm = (top != a);
            if (m_chip.size() == 0 && m_spill.size() > 0) begin
               fill  = 1;
               exp_a = m_base + 4 * (m_spill.size() - 1);
               m_chip.push_back(m_spill.pop_back());
            end
         end
      end
      addr_in = a; ret = 1'b1;
      @(posedge clk); #1;
      ret = 1'b0;
      check("pop_mismatch", stack_mismatch, exp_mm);
      if (fill) finish_xfer(0, exp_a, 0, rand_lat);
      else begin
         check("pop_rdy", rdy, 1);
         check("pop_no_rd", mem_rd, 0);
      end
      check("pop_empty", stack_empty, model_empty());
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] vals[$];
      logic [31:0] v;

      rst = 1'b1; addr_in = '0; branch = 0; ret = 0; mem_rdy = 0;
      config_addr = '0; config_din = '0; config_wr = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Reset state.
      check("rst_ena",   RAS_ena, 1);
      check("rst_empty", stack_empty, 1);
      check("rst_full",  stack_full, 0);
      check("rst_rdy",   rdy, 1);
      check("rst_wr",    mem_wr, 0);
      check("rst_rd",    mem_rd, 0);
      check("rst_mm",    stack_mismatch, 0);
      check("rst_addr",  mem_addr, 0);
      check("rst_din",   mem_din, 0);

      // 33 pushes then 33 matching pops with ideal memory.
      for (int i = 1; i <= 33; i++) do_push(i, 0);
      check("after33_spills", m_spill.size(), 25);
      for (int i = 33; i >= 1; i--) do_pop(i, 0);
      check("drain_empty", stack_empty, 1);
      check("drain_rdy",   rdy, 1);

      // Directed table.
      vecs[0] = '{0, 32'h10, 0, 0};
      vecs[1] = '{1, 32'h14, 1, 1};
      vecs[2] = '{1, 32'h00, 1, 1};
      vecs[3] = '{0, 32'h20, 0, 0};
      vecs[4] = '{0, 32'h24, 0, 0};
      vecs[5] = '{1, 32'h24, 0, 0};
      vecs[6] = '{1, 32'h20, 0, 1};
      for (int i = 0; i < 7; i++) begin
         if (vecs[i].is_pop) do_pop(vecs[i].a, 0);
         else do_push(vecs[i].a, 0);
         check($sformatf("vec%0d_mm", i), stack_mismatch, vecs[i].exp_mm);
         check($sformatf("vec%0d_empty", i), stack_empty, vecs[i].exp_empty);
      end

      // Mismatch pulse lasts exactly one cycle, also on an empty pop.
      do_push(32'h10, 0);
      do_pop(32'h14, 0);
      @(posedge clk); #1;
      check("mm_pulse_end", stack_mismatch, 0);
      check("mm_count0", stack_empty, 1);
      do_pop(32'h0, 0);
      @(posedge clk); #1;
      check("mm_empty_pulse_end", stack_mismatch, 0);

      // Keys and base, then masked spill/refill round trip with random latency.
      cfg_write(3'd1, 32'hdeadbeef);
      cfg_write(3'd2, 32'h12345678);
      cfg_write(3'd3, 32'hcafef00d);
      cfg_write(3'd4, 32'h0badc0de);
      cfg_write(3'd5, 32'h0000_0100);
      cfg_write(3'd6, 32'hffff_ffff);
      vals.delete();
      for (int i = 0; i < 20; i++) begin
         v = $urandom;
         vals.push_back(v);
         do_push(v, 1);
      end
      for (int i = 19; i >= 0; i--) do_pop(vals[i], 1);
      check("key_rt_empty", stack_empty, 1);

      // Disabled: requests ignored, no mismatch on empty pop.
      cfg_write(3'd0, 32'h0);
      check("dis_ena", RAS_ena, 0);
      do_push(32'h55, 0);
      do_pop(32'h66, 0);
      check("dis_empty", stack_empty, 1);
      cfg_write(3'd0, 32'h1);
      check("en_ena", RAS_ena, 1);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 99) < 55) do_push($urandom, 1);
         else if (m_chip.size() > 0 && $urandom_range(0, 3) != 0) do_pop(m_chip[$], 1);
         else do_pop($urandom, 1);
      end

      // Fill both on-chip buffer and spill area; next push is dropped.
      do_reset();
      for (int i = 1; i <= DEPTH + MEM_DEPTH - 1; i++) do_push(i, 0);
      check("not_full_yet", stack_full, 0);
      do_push(32'h8000_0000, 0);
      check("stack_full", stack_full, 1);
      do_push(32'h9999_9999, 0);
      check("full_drop_spills", m_spill.size(), MEM_DEPTH);
      do_pop(32'h8000_0000, 0);
      check("after_full_pop", stack_full, 0);

      // Stalled spill holds its request, then reset aborts it.
      do_reset();
      for (int i = 1; i <= DEPTH; i++) do_push(i, 0);
      addr_in = 32'h77; branch = 1'b1; mem_rdy = 1'b0;
      @(posedge clk); #1;
      branch = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_wr",   mem_wr, 1);
         check("stall_rdy",  rdy, 0);
         check("stall_addr", mem_addr, 0);
         check("stall_din",  mem_din, 1);
         @(posedge clk); #1;
      end
      #2 rst = 1'b1;
      #1;
      check("abort_wr",    mem_wr, 0);
      check("abort_rd",    mem_rd, 0);
      check("abort_rdy",   rdy, 1);
      check("abort_empty", stack_empty, 1);
      check("abort_addr",  mem_addr, 0);
      check("abort_din",   mem_din, 0);
      check("abort_ena",   RAS_ena, 1);
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      do_push(32'h42, 0);
      do_pop(32'h42, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
